iq_free_slot_alloc: RTL
=======================

# iq_free_slot_alloc

Free-slot allocator for the issue queue. Select logic on the read side picks ready entries with first-one priority. This block is the write side: it tracks which issue-queue entries are free, hands up to DISPATCH_WIDTH lowest-index free slots to dispatch each cycle, and reclaims slots released by issue through a one-stage free pipeline. It also provides the dispatch stall and flush recovery.

## Interface
- IQ_SIZE, 32: issue-queue entries; power of two, ≥ DISPATCH_WIDTH.
- DISPATCH_WIDTH, 4: allocation lanes per cycle.
- ISSUE_WIDTH, 4: free (release) lanes per cycle.
- IDX_W, $clog2(IQ_SIZE): slot index width.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous recovery; all slots free at next edge.
- allocReq_i  in  DISPATCH_WIDTH  lane requests; thermometer code from lane 0.
- allocIdx_o  out  DISPATCH_WIDTH×IDX_W  lane k: k-th lowest free slot.
- allocValid_o  out  DISPATCH_WIDTH  lane k has a slot (k < freeCnt).
- stall_o  out  1  dispatch group cannot be fully served; nothing allocated.
- freeValid_i  in  ISSUE_WIDTH  release-lane valid.
- freeIdx_i  in  ISSUE_WIDTH×IDX_W  slot released by issue.
- freeCnt_o  out  IDX_W+1  registered free-slot count.
- errFree_o  out  1  sticky: a release targeted an already-free slot.

## Operation
- State: freeVec_q[IQ_SIZE] (1 = free), freeCnt_q, free pipeline (freeValid_q, freeIdx_q), errFree_q.
- Reset: freeVec_q all ones. freeCnt_q = IQ_SIZE. Pipeline valids 0. errFree_q 0.
- Selection: allocIdx_o/allocValid_o come combinationally from freeVec_q only. Use DISPATCH_WIDTH cascaded first-one selections; each stage masks the bit picked by the prior stage. Same-cycle releases are never visible here.
- reqCnt = popcount(allocReq_i). stall_o = flush_i | (reqCnt > freeCnt_q).
- Commit at edge when !stall_o: clear freeVec bits for lanes 0..reqCnt-1.
- Release: at edge, freeValid_i/freeIdx_i are registered into the pipeline. At the following edge each valid staged index sets its freeVec bit.
- If a staged index is already free: errFree_q sets and stays set until reset. The bit stays 1 and is not counted.
- Counter: freeCnt_q' = freeCnt_q + appliedFrees − committedAllocs. Width IDX_W+1. Never exceeds IQ_SIZE.
- Duplicate indices within one release group count once. This also sets errFree_q.
- Flush at edge overrides everything: freeVec all ones, freeCnt IQ_SIZE, pipeline valids cleared, no allocation. errFree_q is kept.
- Non-thermometer allocReq_i is a protocol violation; the bench asserts on it.

## Timing
- Alloc: indices valid in the same cycle as the request. The slot is unavailable from the next edge.
- Release latency: freeValid_i in cycle t → staged at edge t+1 → freeVec updated at edge t+2 → allocatable in cycle t+2.
- No alloc/free conflict: only free slots are allocated, and only occupied slots are legally released.
- After reset deassertion: allocValid_o = all ones and stall_o = 0 with no idle cycle.
- Reset asserted mid-operation clears all state immediately, including any staged release.

## Structure
- Shared package iq_alloc_pkg: IQ_SIZE/DISPATCH_WIDTH/ISSUE_WIDTH defaults, IDX_W, slot-index typedef, count typedef (IDX_W+1).
- Sub-module free_slot_select: combinational cascade of DISPATCH_WIDTH masked first-one selects with one-hot→index conversion. Outputs indices and valids.
- Top holds freeVec_q, freeCnt_q, the release pipeline, and the stall/commit logic.

## Test plan
- Reset, then allocReq_i=4'b1111 → allocIdx 0,1,2,3, stall_o=0. Next cycle indices 4..7, freeCnt_o=28.
- Fill to 2 free (slots 30,31); allocReq_i=4'b0111 → stall_o=1, freeVec unchanged. allocReq_i=4'b0011 → 30,31 granted, freeCnt_o=0.
- Queue full; release slot 5 in cycle t → allocIdx_o[0]=5 with allocValid_o[0]=1 first in cycle t+2, not t+1.
- Release slots 3 and 9 while allocating 2 in the same cycle → freeCnt_o nets correctly, with frees applied two edges later. Subsequent alloc returns 3 then 9.
- Release an already-free slot 12 → errFree_o=1 and sticky, freeCnt_o unchanged. Flush keeps errFree_o. Reset clears it.
- Staged release pending when flush_i=1 → next cycle freeCnt_o=32 and the release is dropped. Async reset mid-burst → outputs return to reset values immediately.

Source files
------------

// File: rtl/iq_alloc_pkg.sv
// rtl/iq_alloc_pkg.sv - shared sizing and types for the issue-queue slot allocator
package iq_alloc_pkg;

    localparam int DEF_IQ_SIZE        = 32;
    localparam int DEF_DISPATCH_WIDTH = 4;
    localparam int DEF_ISSUE_WIDTH    = 4;
    localparam int DEF_IDX_W          = $clog2(DEF_IQ_SIZE);

    typedef logic [DEF_IDX_W-1:0] slot_idx_t;
    typedef logic [DEF_IDX_W:0]   slot_cnt_t;

endpackage

// File: rtl/free_slot_select.sv
// rtl/free_slot_select.sv - cascaded lowest-first free slot pick for each dispatch lane
module free_slot_select
    import iq_alloc_pkg::*;
#(
    parameter int IQ_SIZE        = DEF_IQ_SIZE,
    parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
    parameter int IDX_W          = $clog2(IQ_SIZE)
) (
    input  logic [IQ_SIZE-1:0]              free_vec,
    output logic [DISPATCH_WIDTH*IDX_W-1:0] sel_idx,
    output logic [DISPATCH_WIDTH-1:0]       sel_valid
);

    logic [IQ_SIZE-1:0] remain;
    logic [IQ_SIZE-1:0] lowest;

    // Each lane isolates the lowest set bit, then removes it for the next lane.
    always_comb begin
        remain    = free_vec;
        lowest    = '0;
        sel_idx   = '0;
        sel_valid = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            lowest       = remain & (~remain + IQ_SIZE'(1));
            sel_valid[k] = |remain;
            for (int i = 0; i < IQ_SIZE; i++) begin
                if (lowest[i]) begin
                    sel_idx[k*IDX_W +: IDX_W] = IDX_W'(i);
                end
            end
            remain = remain & ~lowest;
        end
    end

endmodule

// File: rtl/iq_free_slot_alloc.sv
// rtl/iq_free_slot_alloc.sv - issue-queue free slot tracker with dispatch allocation and release pipeline
module iq_free_slot_alloc
    import iq_alloc_pkg::*;
#(
    parameter int IQ_SIZE        = DEF_IQ_SIZE,
    parameter int DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH    = DEF_ISSUE_WIDTH,
    parameter int IDX_W          = $clog2(IQ_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [DISPATCH_WIDTH-1:0]       allocReq_i,
    output logic [DISPATCH_WIDTH*IDX_W-1:0] allocIdx_o,
    output logic [DISPATCH_WIDTH-1:0]       allocValid_o,
    output logic                            stall_o,
    input  logic [ISSUE_WIDTH-1:0]          freeValid_i,
    input  logic [ISSUE_WIDTH*IDX_W-1:0]    freeIdx_i,
    output logic [IDX_W:0]                  freeCnt_o,
    output logic                            errFree_o
);

    logic [IQ_SIZE-1:0]           free_vec_q;
    logic [IDX_W:0]               free_cnt_q;
    logic [ISSUE_WIDTH-1:0]       free_valid_q;
    logic [ISSUE_WIDTH*IDX_W-1:0] free_idx_q;
    logic                         err_free_q;

    logic [DISPATCH_WIDTH*IDX_W-1:0] sel_idx;
    logic [DISPATCH_WIDTH-1:0]       sel_valid;
    logic [IDX_W:0]                  req_cnt;
    logic [IDX_W:0]                  commit_cnt;
    logic [IDX_W:0]                  staged_cnt;
    logic [IDX_W:0]                  applied_cnt;
    logic [IQ_SIZE-1:0]              alloc_mask;
    logic [IQ_SIZE-1:0]              rel_mask;
    logic [IQ_SIZE-1:0]              newly_free;
    logic                            stall;

    free_slot_select #(
        .IQ_SIZE        (IQ_SIZE),
        .DISPATCH_WIDTH (DISPATCH_WIDTH),
        .IDX_W          (IDX_W)
    ) u_select (
        .free_vec  (free_vec_q),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    always_comb begin
        req_cnt = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            req_cnt = req_cnt + (IDX_W+1)'(allocReq_i[k]);
        end
    end

    assign stall      = flush_i | (req_cnt > free_cnt_q);
    assign commit_cnt = stall ? '0 : req_cnt;

    always_comb begin
        alloc_mask = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            if (!stall && ((IDX_W+1)'(k) < req_cnt)) begin
                alloc_mask[sel_idx[k*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    // Duplicates and already-free targets collapse in the mask, so a shortfall
    // between staged and applied counts is exactly the error condition.
    always_comb begin
        rel_mask   = '0;
        staged_cnt = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (free_valid_q[i]) begin
                rel_mask[free_idx_q[i*IDX_W +: IDX_W]] = 1'b1;
                staged_cnt = staged_cnt + (IDX_W+1)'(1);
            end
        end
        newly_free  = rel_mask & ~free_vec_q;
        applied_cnt = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            applied_cnt = applied_cnt + (IDX_W+1)'(newly_free[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_vec_q   <= '1;
            free_cnt_q   <= (IDX_W+1)'(IQ_SIZE);
            free_valid_q <= '0;
            free_idx_q   <= '0;
            err_free_q   <= 1'b0;
        end else if (flush_i) begin
            free_vec_q   <= '1;
            free_cnt_q   <= (IDX_W+1)'(IQ_SIZE);
            free_valid_q <= '0;
        end else begin
            free_vec_q   <= (free_vec_q & ~alloc_mask) | rel_mask;
            free_cnt_q   <= free_cnt_q + applied_cnt - commit_cnt;
            free_valid_q <= freeValid_i;
            free_idx_q   <= freeIdx_i;
            err_free_q   <= err_free_q | (staged_cnt != applied_cnt);
        end
    end

    assign allocIdx_o   = sel_idx;
    assign allocValid_o = sel_valid;
    assign stall_o      = stall;
    assign freeCnt_o    = free_cnt_q;
    assign errFree_o    = err_free_q;

endmodule
